// File: rtl/pow_n_pipelined_axis.sv
// rtl/pow_n_pipelined_axis.sv - x^POW stream pipeline, one multiplier per stage, full tready backpressure
// Stage k holds x^(k+1) in the low (k+1)*DATA_WIDTH bits of a POW*DATA_WIDTH-wide register.
module pow_n_pipelined_axis #(
    parameter int DATA_WIDTH = 8,
    parameter int POW        = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_WIDTH-1:0]      s_tdata_i,
    input  logic                       s_tvalid_i,
    input  logic                       s_tlast_i,
    output logic                       s_tready_o,
    output logic [POW*DATA_WIDTH-1:0]  m_tdata_o,
    output logic                       m_tvalid_o,
    output logic                       m_tlast_o,
    input  logic                       m_tready_i,
    output logic                       busy_o
);

    localparam int PW = POW * DATA_WIDTH;

    logic [POW-1:0]                 v_q, v_d;
    logic [POW-1:0]                 last_q, last_d;
    logic [POW-1:0]                 adv;
    logic [POW-1:0]                 load;
    logic [POW-2:0][DATA_WIDTH-1:0] x_q, x_d;
    logic [POW-1:0][PW-1:0]         p_q, p_d;

    // Advance resolves from the output stage backwards so a full pipe can shift while draining.
    always_comb begin
        adv = '0;
        adv[POW-1] = v_q[POW-1] & m_tready_i;
        for (int k = POW - 2; k >= 0; k--) begin
            adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
        end
        load = ~v_q | adv;
    end

    always_comb begin
        v_d    = v_q;
        last_d = last_q;
        x_d    = x_q;
        p_d    = p_q;

        if (load[0]) begin
            v_d[0]    = s_tvalid_i;
            last_d[0] = s_tlast_i;
            x_d[0]    = s_tdata_i;
            p_d[0]    = {{(PW - DATA_WIDTH){1'b0}}, s_tdata_i};
        end

        for (int k = 1; k < POW; k++) begin
            if (load[k]) begin
                v_d[k]    = v_q[k-1] & adv[k-1];
                last_d[k] = last_q[k-1];
                p_d[k]    = p_q[k-1] * {{(PW - DATA_WIDTH){1'b0}}, x_q[k-1]};
            end
        end

        // The last stage has no consumer for x, so the delay line stops one stage short.
        for (int k = 1; k < POW - 1; k++) begin
            if (load[k]) begin
                x_d[k] = x_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q    <= '0;
            last_q <= '0;
            x_q    <= '0;
            p_q    <= '0;
        end else begin
            v_q    <= v_d;
            last_q <= last_d;
            x_q    <= x_d;
            p_q    <= p_d;
        end
    end

    // Ready is held low during reset so nothing offered in that cycle counts as accepted.
    assign s_tready_o = load[0] & ~rst_i;
    assign m_tdata_o  = p_q[POW-1];
    assign m_tvalid_o = v_q[POW-1];
    assign m_tlast_o  = last_q[POW-1];
    assign busy_o     = |v_q;

endmodule

// File: tb/tb_pow_n_pipelined_axis.sv
// tb/tb_pow_n_pipelined_axis.sv - self-checking bench for pow_n_pipelined_axis
module tb_pow_n_pipelined_axis;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: DATA_WIDTH=8, POW=5
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [39:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready, busy;

    pow_n_pipelined_axis #(.DATA_WIDTH(8), .POW(5)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tready_i(m_tready),
        .busy_o(busy)
    );

    // DATA_WIDTH=8, POW=2
    logic [7:0]  a_s_tdata;
    logic        a_s_tvalid, a_s_tlast, a_s_tready;
    logic [15:0] a_m_tdata;
    logic        a_m_tvalid, a_m_tlast, a_m_tready, a_busy;

    pow_n_pipelined_axis #(.DATA_WIDTH(8), .POW(2)) dut_p2 (
        .clk_i(clk), .rst_i(rst),
        .s_tdata_i(a_s_tdata), .s_tvalid_i(a_s_tvalid), .s_tlast_i(a_s_tlast), .s_tready_o(a_s_tready),
        .m_tdata_o(a_m_tdata), .m_tvalid_o(a_m_tvalid), .m_tlast_o(a_m_tlast), .m_tready_i(a_m_tready),
        .busy_o(a_busy)
    );

    // DATA_WIDTH=4, POW=8
    logic [3:0]  b_s_tdata;
    logic        b_s_tvalid, b_s_tlast, b_s_tready;
    logic [31:0] b_m_tdata;
    logic        b_m_tvalid, b_m_tlast, b_m_tready, b_busy;

    pow_n_pipelined_axis #(.DATA_WIDTH(4), .POW(8)) dut_p8 (
        .clk_i(clk), .rst_i(rst),
        .s_tdata_i(b_s_tdata), .s_tvalid_i(b_s_tvalid), .s_tlast_i(b_s_tlast), .s_tready_o(b_s_tready),
        .m_tdata_o(b_m_tdata), .m_tvalid_o(b_m_tvalid), .m_tlast_o(b_m_tlast), .m_tready_i(b_m_tready),
        .busy_o(b_busy)
    );

    typedef struct {
        logic [7:0]  x;
        logic        last;
        logic [63:0] exp_v;
    } vec_t;

    vec_t tbl [7];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [63:0] ipow(input logic [63:0] x, input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * x;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [7:0] x, input logic [63:0] e, input string nm);
        int lat, nv;
        logic [63:0] d;
        lat = 0; nv = 0; d = '0;
        m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = x; s_tlast = 1'b1;
        #1;
        chk({nm, "_s_tready"}, 64'(s_tready), 64'd1);
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (m_tvalid) begin
                nv++;
                if (lat == 0) begin
                    lat = c;
                    d = 64'(m_tdata);
                end
            end
            tick();
        end
        chk({nm, "_latency"}, 64'(lat), 64'd5);
        chk({nm, "_data"}, d, e);
        chk({nm, "_valid_cycles"}, 64'(nv), 64'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int out_idx, bad_t, rdy_bad, extra, nxt, stall_bad, seen;
        int sent, got, stab_bad, hold_v, nvalid, lat2, lat8;
        logic [40:0] q[$];
        logic [40:0] hold, e;
        logic [63:0] pw, d2, d8;
        logic [7:0] rx;
        logic rl;

        for (int i = 0; i < 7; i++) begin
            tbl[i].x    = 8'(i + 1);
            tbl[i].last = (i == 5);
        end
        tbl[0].exp_v = 64'd1;     tbl[1].exp_v = 64'd32;    tbl[2].exp_v = 64'd243;
        tbl[3].exp_v = 64'd1024;  tbl[4].exp_v = 64'd3125;  tbl[5].exp_v = 64'd7776;
        tbl[6].exp_v = 64'd16807;

        rst = 1'b1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        a_s_tdata = '0; a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_m_tready = 1'b1;
        b_s_tdata = '0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b1;
        tick(); tick();
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_s_tready", 64'(s_tready), 64'd1);
        tick();

        single(8'd3, 64'd243, "single3");
        single(8'd255, 64'd1078203909375, "single255");

        // Back-to-back 1..6, tlast on 6
        m_tready = 1'b1;
        out_idx = 0; bad_t = 0; rdy_bad = 0; extra = 0;
        for (int t = 0; t < 15; t++) begin
            if (m_tvalid) begin
                if (out_idx < 6) begin
                    chk("b2b_sample", {23'd0, m_tlast, m_tdata},
                        {23'd0, tbl[out_idx].last, tbl[out_idx].exp_v[39:0]});
                    if (out_idx != t - 5) bad_t++;
                    out_idx++;
                end else extra++;
            end
            if (t < 6) begin
                s_tvalid = 1'b1; s_tdata = tbl[t].x; s_tlast = tbl[t].last;
            end else begin
                s_tvalid = 1'b0; s_tlast = 1'b0;
            end
            #1;
            if (t < 6 && !s_tready) rdy_bad++;
            tick();
        end
        chk("b2b_count", 64'(out_idx), 64'd6);
        chk("b2b_timing", 64'(bad_t), 64'd0);
        chk("b2b_extra", 64'(extra), 64'd0);
        chk("b2b_ready", 64'(rdy_bad), 64'd0);

        // Stall: m_tready low, offer 1..7
        m_tready = 1'b0;
        nxt = 0; stall_bad = 0; seen = 0;
        for (int t = 0; t < 12; t++) begin
            if (seen != 0 && (!m_tvalid || m_tdata !== 40'd1 || m_tlast !== 1'b0)) stall_bad++;
            if (m_tvalid) seen = 1;
            s_tvalid = 1'b1; s_tdata = tbl[nxt].x; s_tlast = tbl[nxt].last;
            #1;
            if (s_tready) nxt++;
            tick();
        end
        #1;
        chk("stall_accepted", 64'(nxt), 64'd5);
        chk("stall_s_tready", 64'(s_tready), 64'd0);
        chk("stall_stable", 64'(stall_bad), 64'd0);
        chk("stall_m_tvalid", 64'(m_tvalid), 64'd1);
        chk("stall_m_tdata", 64'(m_tdata), 64'd1);

        m_tready = 1'b1;
        out_idx = 0; extra = 0;
        for (int t = 0; t < 20; t++) begin
            if (m_tvalid) begin
                if (out_idx < 7) begin
                    chk("drain_sample", {23'd0, m_tlast, m_tdata},
                        {23'd0, tbl[out_idx].last, tbl[out_idx].exp_v[39:0]});
                    out_idx++;
                end else extra++;
            end
            if (nxt < 7) begin
                s_tvalid = 1'b1; s_tdata = tbl[nxt].x; s_tlast = tbl[nxt].last;
            end else begin
                s_tvalid = 1'b0; s_tlast = 1'b0;
            end
            #1;
            if (t == 0) chk("full_drain_accept", 64'(s_tready), 64'd1);
            if (s_tvalid && s_tready) nxt++;
            tick();
        end
        chk("drain_count", 64'(out_idx), 64'd7);
        chk("drain_accepted", 64'(nxt), 64'd7);
        chk("drain_extra", 64'(extra), 64'd0);

        // Random traffic against a queue scoreboard
        sent = 0; got = 0; stab_bad = 0; hold_v = 0; extra = 0; hold = '0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            if (hold_v != 0 && (!m_tvalid || {m_tlast, m_tdata} !== hold)) stab_bad++;
            m_tready = 1'($urandom_range(0, 1));
            if (sent < 1000) begin
                s_tvalid = 1'($urandom_range(0, 1));
                rx = 8'($urandom);
                rl = 1'($urandom_range(0, 1));
                s_tdata = rx; s_tlast = rl;
            end else begin
                s_tvalid = 1'b0;
            end
            #1;
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) extra++;
                else begin
                    e = q.pop_front();
                    chk("rand_sample", {23'd0, m_tlast, m_tdata}, {23'd0, e});
                end
                got++;
            end
            hold_v = (m_tvalid && !m_tready) ? 1 : 0;
            hold = {m_tlast, m_tdata};
            if (s_tvalid && s_tready) begin
                pw = ipow(64'(s_tdata), 5);
                q.push_back({s_tlast, pw[39:0]});
                sent++;
            end
            tick();
        end
        s_tvalid = 1'b0;
        chk("rand_got", 64'(got), 64'd1000);
        chk("rand_sent", 64'(sent), 64'd1000);
        chk("rand_leftover", 64'(q.size()), 64'd0);
        chk("rand_extra", 64'(extra), 64'd0);
        chk("rand_stable", 64'(stab_bad), 64'd0);

        // Reset with three samples in flight
        m_tready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            s_tvalid = 1'b1; s_tdata = 8'(10 + t); s_tlast = 1'b0;
            tick();
        end
        rst = 1'b1; s_tvalid = 1'b1; s_tdata = 8'd9;
        tick();
        rst = 1'b0; s_tvalid = 1'b0;
        chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        #1;
        chk("midrst_s_tready", 64'(s_tready), 64'd1);
        nvalid = 0;
        for (int t = 0; t < 10; t++) begin
            if (m_tvalid) nvalid++;
            tick();
        end
        chk("midrst_no_stale", 64'(nvalid), 64'd0);
        single(8'd2, 64'd32, "post_rst2");

        // Other parametrisations
        a_s_tvalid = 1'b1; a_s_tdata = 8'd200; a_s_tlast = 1'b1;
        b_s_tvalid = 1'b1; b_s_tdata = 4'd15;  b_s_tlast = 1'b1;
        tick();
        a_s_tvalid = 1'b0; b_s_tvalid = 1'b0;
        lat2 = 0; lat8 = 0; d2 = '0; d8 = '0;
        for (int c = 1; c <= 12; c++) begin
            if (a_m_tvalid && lat2 == 0) begin lat2 = c; d2 = 64'(a_m_tdata); end
            if (b_m_tvalid && lat8 == 0) begin lat8 = c; d8 = 64'(b_m_tdata); end
            tick();
        end
        chk("pow2_latency", 64'(lat2), 64'd2);
        chk("pow2_data", d2, 64'd40000);
        chk("pow8_latency", 64'(lat8), 64'd8);
        chk("pow8_data", d8, 64'd2562890625);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
